// File: rtl/idma_reg64_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : idma_reg64_driver_pkg
// Description : Shared register map, CONF bit indices, FSM state encoding and
//               register-interface request/response layouts for the 64-bit
//               iDMA register-frontend driver.
// Revision    : 1.0 - initial release
// ============================================================================
package idma_reg64_driver_pkg;

    // Register offsets of the 64-bit DMA register frontend
    localparam logic [31:0] c_reg_conf    = 32'h0000_0000;
    localparam logic [31:0] c_reg_next_id = 32'h0000_0010;
    localparam logic [31:0] c_reg_done    = 32'h0000_0018;
    localparam logic [31:0] c_reg_src     = 32'h0000_0020;
    localparam logic [31:0] c_reg_dst     = 32'h0000_0028;
    localparam logic [31:0] c_reg_len     = 32'h0000_0030;

    // CONF register bit positions
    localparam int unsigned c_conf_decouple_bit = 0;
    localparam int unsigned c_conf_deburst_bit  = 1;

    // Driver FSM states
    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        WR_SRC    = 4'd1,
        WR_DST    = 4'd2,
        WR_LEN    = 4'd3,
        WR_CONF   = 4'd4,
        RD_NEXTID = 4'd5,
        POLL_WAIT = 4'd6,
        RD_DONE   = 4'd7
    } state_e;

    // Register-interface request / response layouts
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic        valid;
    } reg64_req_t;

    typedef struct packed {
        logic [63:0] rdata;
        logic        error;
        logic        ready;
    } reg64_rsp_t;

    // Full-width write request
    function automatic reg64_req_t reg_write(input logic [31:0] addr, input logic [63:0] data);
        reg64_req_t req;
        req.addr  = addr;
        req.write = 1'b1;
        req.wdata = data;
        req.wstrb = 8'hFF;
        req.valid = 1'b1;
        return req;
    endfunction

    // Read request
    function automatic reg64_req_t reg_read(input logic [31:0] addr);
        reg64_req_t req;
        req.addr  = addr;
        req.write = 1'b0;
        req.wdata = '0;
        req.wstrb = '0;
        req.valid = 1'b1;
        return req;
    endfunction

endpackage
`default_nettype wire

// File: rtl/idma_reg64_driver.sv
`default_nettype none
// ============================================================================
// Module      : idma_reg64_driver
// Description : Accepts a transfer descriptor, programs SRC/DST/LEN/CONF over
//               a register interface, reads NEXT_ID and optionally polls DONE
//               until the transfer retires.
// Revision    : 1.0 - initial release
// ============================================================================
module idma_reg64_driver
    import idma_reg64_driver_pkg::*;
#(
    parameter type         reg_req_t = logic,
    parameter type         reg_rsp_t = logic,
    parameter int unsigned PollGap   = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [63:0] desc_src_i,
    input  logic [63:0] desc_dst_i,
    input  logic [63:0] desc_len_i,
    input  logic        desc_decouple_i,
    input  logic        desc_deburst_i,
    input  logic        desc_wait_i,
    input  logic        desc_valid_i,
    output logic        desc_ready_o,
    output reg_req_t    reg_req_o,
    input  reg_rsp_t    reg_rsp_i,
    output logic [63:0] id_o,
    output logic        id_valid_o,
    output logic        done_o,
    output logic        error_o,
    output logic        busy_o
);

    // At least one counter bit so PollGap == 0 still elaborates
    localparam int unsigned c_cnt_w = (PollGap > 0) ? $clog2(PollGap + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(PollGap - 1);

    state_e               r_state;
    reg64_req_t           r_req;
    logic [63:0]          r_src;
    logic [63:0]          r_dst;
    logic [63:0]          r_len;
    logic                 r_decouple;
    logic                 r_deburst;
    logic                 r_wait;
    logic [63:0]          r_id;
    logic                 r_id_valid;
    logic                 r_done;
    logic                 r_error;
    logic [c_cnt_w-1:0]   r_cnt;

    reg64_rsp_t           w_rsp;
    logic [63:0]          w_conf;
    logic [63:0]          w_diff;
    logic                 w_retired;

    // Decode the response and build the CONF word from the latched descriptor
    always_comb begin
        w_rsp                       = reg64_rsp_t'(reg_rsp_i);
        w_conf                      = '0;
        w_conf[c_conf_decouple_bit] = r_decouple;
        w_conf[c_conf_deburst_bit]  = r_deburst;
        // Wrap-safe retire check: DONE has reached or passed our ID
        w_diff                      = w_rsp.rdata - r_id;
        w_retired                   = ~w_diff[63];
    end

    // Driver FSM with registered request and status pulses
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_req      <= '0;
            r_src      <= '0;
            r_dst      <= '0;
            r_len      <= '0;
            r_decouple <= 1'b0;
            r_deburst  <= 1'b0;
            r_wait     <= 1'b0;
            r_id       <= '0;
            r_id_valid <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_id_valid <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (desc_valid_i) begin
                        r_src      <= desc_src_i;
                        r_dst      <= desc_dst_i;
                        r_len      <= desc_len_i;
                        r_decouple <= desc_decouple_i;
                        r_deburst  <= desc_deburst_i;
                        r_wait     <= desc_wait_i;
                        if (desc_len_i == 64'd0) begin
                            r_error <= 1'b1;
                        end else begin
                            r_state <= WR_SRC;
                            r_req   <= reg_write(c_reg_src, desc_src_i);
                        end
                    end
                end
                POLL_WAIT: begin
                    if (r_cnt == c_cnt_last) begin
                        r_state <= RD_DONE;
                        r_req   <= reg_read(c_reg_done);
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                default: begin
                    // Access states: hold the request until the frontend accepts it
                    if (w_rsp.ready) begin
                        if (w_rsp.error) begin
                            r_state <= IDLE;
                            r_req   <= '0;
                            r_error <= 1'b1;
                        end else begin
                            case (r_state)
                                WR_SRC: begin
                                    r_state <= WR_DST;
                                    r_req   <= reg_write(c_reg_dst, r_dst);
                                end
                                WR_DST: begin
                                    r_state <= WR_LEN;
                                    r_req   <= reg_write(c_reg_len, r_len);
                                end
                                WR_LEN: begin
                                    r_state <= WR_CONF;
                                    r_req   <= reg_write(c_reg_conf, w_conf);
                                end
                                WR_CONF: begin
                                    r_state <= RD_NEXTID;
                                    r_req   <= reg_read(c_reg_next_id);
                                end
                                RD_NEXTID: begin
                                    r_id       <= w_rsp.rdata;
                                    r_id_valid <= 1'b1;
                                    if (!r_wait) begin
                                        r_state <= IDLE;
                                        r_req   <= '0;
                                    end else if (PollGap == 0) begin
                                        r_state <= RD_DONE;
                                        r_req   <= reg_read(c_reg_done);
                                    end else begin
                                        r_state <= POLL_WAIT;
                                        r_req   <= '0;
                                        r_cnt   <= '0;
                                    end
                                end
                                RD_DONE: begin
                                    if (w_retired) begin
                                        r_done  <= 1'b1;
                                        r_state <= IDLE;
                                        r_req   <= '0;
                                    end else if (PollGap == 0) begin
                                        r_req   <= reg_read(c_reg_done);
                                    end else begin
                                        r_state <= POLL_WAIT;
                                        r_req   <= '0;
                                        r_cnt   <= '0;
                                    end
                                end
                                default: begin
                                    r_state <= IDLE;
                                    r_req   <= '0;
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

    assign desc_ready_o = (r_state == IDLE);
    assign busy_o       = (r_state != IDLE);
    assign reg_req_o    = reg_req_t'(r_req);
    assign id_o         = r_id;
    assign id_valid_o   = r_id_valid;
    assign done_o       = r_done;
    assign error_o      = r_error;

endmodule
`default_nettype wire

// File: tb/tb_idma_reg64_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_idma_reg64_driver
// Description : Directed self-checking bench for idma_reg64_driver with a
//               scripted register-frontend responder and access logger.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_idma_reg64_driver;
    import idma_reg64_driver_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] desc_src, desc_dst, desc_len;
    logic        desc_decouple, desc_deburst, desc_wait, desc_valid, desc_ready;
    reg64_req_t  reg_req;
    reg64_rsp_t  reg_rsp;
    logic [63:0] id;
    logic        id_valid, done, error, busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    idma_reg64_driver #(
        .reg_req_t (reg64_req_t),
        .reg_rsp_t (reg64_rsp_t),
        .PollGap   (4)
    ) u_dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .desc_src_i      (desc_src),
        .desc_dst_i      (desc_dst),
        .desc_len_i      (desc_len),
        .desc_decouple_i (desc_decouple),
        .desc_deburst_i  (desc_deburst),
        .desc_wait_i     (desc_wait),
        .desc_valid_i    (desc_valid),
        .desc_ready_o    (desc_ready),
        .reg_req_o       (reg_req),
        .reg_rsp_i       (reg_rsp),
        .id_o            (id),
        .id_valid_o      (id_valid),
        .done_o          (done),
        .error_o         (error),
        .busy_o          (busy)
    );

    // Responder script (written only by the stimulus block)
    int unsigned stall_len   = 0;
    logic [31:0] err_addr    = 32'hFFFF_FFFF;
    logic [63:0] next_id_val = '0;
    logic [63:0] done_q[$];

    // Responder / logger state (written only by the logger block)
    int unsigned stall_ctr = 0;
    int unsigned done_rd   = 0;
    int unsigned cyc       = 0;
    int unsigned n_idv     = 0;
    int unsigned n_done    = 0;
    int unsigned n_err     = 0;
    logic [31:0] log_addr[$];
    logic [63:0] log_wdata[$];
    logic        log_write[$];
    logic [7:0]  log_wstrb[$];
    int unsigned log_cyc[$];

    // Register frontend model: stalls LEN writes, injects errors, serves reads
    always @* begin
        reg_rsp = '0;
        if (reg_req.valid) begin
            reg_rsp.ready = (reg_req.addr != c_reg_len) || (stall_ctr >= stall_len);
            reg_rsp.error = reg_rsp.ready && (reg_req.addr == err_addr);
            if (reg_req.addr == c_reg_next_id)
                reg_rsp.rdata = next_id_val;
            else if (reg_req.addr == c_reg_done && done_rd < done_q.size())
                reg_rsp.rdata = done_q[done_rd];
        end
    end

    // Access log and pulse counters
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n) begin
            if (reg_req.valid && reg_rsp.ready) begin
                log_addr.push_back(reg_req.addr);
                log_wdata.push_back(reg_req.wdata);
                log_write.push_back(reg_req.write);
                log_wstrb.push_back(reg_req.wstrb);
                log_cyc.push_back(cyc);
                if (reg_req.addr == c_reg_done) done_rd <= done_rd + 1;
                if (reg_req.addr == c_reg_len)  stall_ctr <= 0;
            end else if (reg_req.valid && reg_req.addr == c_reg_len) begin
                stall_ctr <= stall_ctr + 1;
            end
            if (id_valid) n_idv  <= n_idv + 1;
            if (done)     n_done <= n_done + 1;
            if (error)    n_err  <= n_err + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check one logged access against its expected address/direction/data
    task automatic chk_access(input string tag, input int idx, input logic [31:0] a,
                              input logic w, input logic [63:0] d);
        chk($sformatf("%s_addr%0d", tag, idx), 64'(log_addr[idx]), 64'(a));
        chk($sformatf("%s_write%0d", tag, idx), 64'(log_write[idx]), 64'(w));
        if (w) begin
            chk($sformatf("%s_wdata%0d", tag, idx), log_wdata[idx], d);
            chk($sformatf("%s_wstrb%0d", tag, idx), 64'(log_wstrb[idx]), 64'hFF);
        end
    endtask

    task automatic send(input logic [63:0] s, input logic [63:0] d, input logic [63:0] l,
                        input logic dec, input logic deb, input logic wt);
        chk("ready_before_send", 64'(desc_ready), 64'd1);
        desc_src      = s;
        desc_dst      = d;
        desc_len      = l;
        desc_decouple = dec;
        desc_deburst  = deb;
        desc_wait     = wt;
        desc_valid    = 1'b1;
        @(negedge clk);
        desc_valid    = 1'b0;
    endtask

    task automatic run_idle(input string tag, input int budget);
        for (int n = 0; n < budget; n++) begin
            if (!busy) break;
            @(negedge clk);
        end
        chk({tag, "_idle"}, 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_addr(input string tag, input logic [31:0] a);
        int n;
        for (n = 0; n < 50; n++) begin
            if (reg_req.valid && reg_req.addr == a) break;
            @(negedge clk);
        end
        chk({tag, "_reached"}, 64'(n < 50), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int unsigned bi, bd, be;

        rst_n = 1'b0;
        desc_src = '0; desc_dst = '0; desc_len = '0;
        desc_decouple = 1'b0; desc_deburst = 1'b0; desc_wait = 1'b0; desc_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(reg_req.valid), 64'd0);
        chk("rst_req", 64'(reg_req.addr), 64'd0);
        chk("rst_id", id, 64'd0);
        chk("rst_pulses", {61'd0, id_valid, done, error}, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(desc_ready), 64'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Plain transfer, no wait, decouple set
        base = log_addr.size(); bi = n_idv; bd = n_done; be = n_err;
        next_id_val = 64'd5;
        send(64'h1000, 64'h2000, 64'h40, 1'b1, 1'b0, 1'b0);
        run_idle("s1", 100);
        chk("s1_count", 64'(log_addr.size() - base), 64'd5);
        chk_access("s1", base + 0, 32'h20, 1'b1, 64'h1000);
        chk_access("s1", base + 1, 32'h28, 1'b1, 64'h2000);
        chk_access("s1", base + 2, 32'h30, 1'b1, 64'h40);
        chk_access("s1", base + 3, 32'h00, 1'b1, 64'h1);
        chk_access("s1", base + 4, 32'h10, 1'b0, 64'h0);
        chk("s1_id", id, 64'd5);
        chk("s1_idv", 64'(n_idv - bi), 64'd1);
        chk("s1_done", 64'(n_done - bd), 64'd0);
        chk("s1_err", 64'(n_err - be), 64'd0);

        // LEN write stalled 3 cycles, deburst set
        base = log_addr.size(); bi = n_idv;
        stall_len = 3;
        next_id_val = 64'd9;
        send(64'hA, 64'hB, 64'h77, 1'b0, 1'b1, 1'b0);
        wait_addr("s2_len", c_reg_len);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("s2_stable%0d", k),
                {reg_req.valid, reg_req.write, reg_req.addr[5:0], reg_req.wdata[55:0]},
                {1'b1, 1'b1, 6'h30, 56'h77});
            @(negedge clk);
        end
        stall_len = 0;
        run_idle("s2", 100);
        chk("s2_count", 64'(log_addr.size() - base), 64'd5);
        chk_access("s2", base + 2, 32'h30, 1'b1, 64'h77);
        chk_access("s2", base + 3, 32'h00, 1'b1, 64'h2);
        chk("s2_id", id, 64'd9);
        chk("s2_idv", 64'(n_idv - bi), 64'd1);

        // Wait for retire: DONE returns 6, 6, 7 against id 7
        base = log_addr.size(); bd = n_done;
        next_id_val = 64'd7;
        done_q.push_back(64'd6); done_q.push_back(64'd6); done_q.push_back(64'd7);
        send(64'h100, 64'h200, 64'h8, 1'b0, 1'b0, 1'b1);
        run_idle("s3", 200);
        chk("s3_count", 64'(log_addr.size() - base), 64'd8);
        chk_access("s3", base + 5, 32'h18, 1'b0, 64'h0);
        chk_access("s3", base + 7, 32'h18, 1'b0, 64'h0);
        chk("s3_gap0", 64'(log_cyc[base + 5] - log_cyc[base + 4]), 64'd5);
        chk("s3_gap1", 64'(log_cyc[base + 6] - log_cyc[base + 5]), 64'd5);
        chk("s3_gap2", 64'(log_cyc[base + 7] - log_cyc[base + 6]), 64'd5);
        chk("s3_done", 64'(n_done - bd), 64'd1);
        chk("s3_id", id, 64'd7);

        // Wrap-around retire: id 1, DONE returns all-ones then 1
        base = log_addr.size(); bd = n_done;
        next_id_val = 64'd1;
        done_q.push_back(64'hFFFF_FFFF_FFFF_FFFF); done_q.push_back(64'd1);
        send(64'h300, 64'h400, 64'h10, 1'b1, 1'b1, 1'b1);
        run_idle("s4", 200);
        chk("s4_count", 64'(log_addr.size() - base), 64'd7);
        chk_access("s4", base + 3, 32'h00, 1'b1, 64'h3);
        chk("s4_done", 64'(n_done - bd), 64'd1);

        // Zero-length descriptor is rejected without any access
        base = log_addr.size(); be = n_err; bi = n_idv;
        send(64'h1, 64'h2, 64'h0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        chk("s5_count", 64'(log_addr.size() - base), 64'd0);
        chk("s5_err", 64'(n_err - be), 64'd1);
        chk("s5_busy", 64'(busy), 64'd0);

        // Error response on DST write aborts the sequence
        base = log_addr.size(); be = n_err; bi = n_idv; bd = n_done;
        err_addr = c_reg_dst;
        send(64'h5000, 64'h6000, 64'h20, 1'b0, 1'b0, 1'b1);
        run_idle("s6", 100);
        err_addr = 32'hFFFF_FFFF;
        chk("s6_count", 64'(log_addr.size() - base), 64'd2);
        chk("s6_err", 64'(n_err - be), 64'd1);
        chk("s6_idv", 64'(n_idv - bi), 64'd0);
        chk("s6_done", 64'(n_done - bd), 64'd0);
        chk("s6_id_kept", id, 64'd1);

        // Reset in the middle of the CONF write
        next_id_val = 64'd3;
        send(64'h7000, 64'h8000, 64'h30, 1'b1, 1'b0, 1'b0);
        wait_addr("s7_conf", c_reg_conf);
        rst_n = 1'b0;
        @(negedge clk);
        chk("s7_valid", 64'(reg_req.valid), 64'd0);
        chk("s7_busy", 64'(busy), 64'd0);
        chk("s7_ready", 64'(desc_ready), 64'd1);
        chk("s7_id", id, 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
